// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its load path.
//   opcode_t  : instruction opcode (ZERO is the idle/reset value)
//   operand_t : signed 32-bit operand
//   address_t : instruction register entry index (32 entries)
//   req_t     : one requester's opcode/operand bundle
//   is_zero_div() flags DIV/MOD with a zero divisor, which must never be loaded.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } req_t;

    function automatic logic is_zero_div(input req_t r);
        return ((r.opc == DIV) || (r.opc == MOD)) && (r.op_b == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   valid[1:0] : request lines
//   advance    : a transfer was accepted this cycle; remember the winner
//   grant[1:0] : one-hot selection (all zero when nobody requests)
// After reset last_grant is 1 so input 0 wins the first contention.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_reg;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: favour whoever did not win last time.
            2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (advance) begin
            last_grant_reg <= grant[1];
        end
    end

endmodule

// File: rtl/instr_load_arbiter.sv
// Shares the instruction register's single write port between two requesters.
//   clk, reset, flush           : clock, async active-high reset, sync pointer/count clear
//   reqN_valid/ready            : valid/ready handshake per requester (N = 0, 1)
//   reqN_opcode/operand_a/b     : instruction offered by requester N
//   reqN_err                    : one-cycle pulse when requester N's DIV/MOD by zero is dropped
//   load_en, opcode, operand_a/b: registered write beat to the instruction register
//   write_pointer               : entry written by the current beat
//   wr_count, full              : entries loaded since reset/flush, and wr_count == DEPTH
//   grant_id                    : requester owning the current beat
module instr_load_arbiter
    import instr_register_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  opcode_t           req0_opcode,
    input  operand_t          req0_operand_a,
    input  operand_t          req0_operand_b,
    output logic              req0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  opcode_t           req1_opcode,
    input  operand_t          req1_operand_a,
    input  operand_t          req1_operand_b,
    output logic              req1_err,
    output logic              load_en,
    output opcode_t           opcode,
    output operand_t          operand_a,
    output operand_t          operand_b,
    output logic [ADDR_W-1:0] write_pointer,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              grant_id
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    req_t        req_arr [2];
    logic [1:0]  valid_vec;
    logic [1:0]  grant_vec;
    logic [1:0]  ready_vec;
    logic [1:0]  accept_vec;
    logic [1:0]  err_next;
    logic        can_accept;
    logic        accept_any;
    logic        load_next;
    req_t        sel_req;

    logic              load_en_reg;
    logic [1:0]        err_reg;
    opcode_t           opcode_reg;
    operand_t          operand_a_reg;
    operand_t          operand_b_reg;
    logic              grant_id_reg;
    logic [ADDR_W-1:0] wp_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              full_reg;

    assign req_arr[0] = '{opc: req0_opcode, op_a: req0_operand_a, op_b: req0_operand_b};
    assign req_arr[1] = '{opc: req1_opcode, op_a: req1_operand_a, op_b: req1_operand_b};
    assign valid_vec  = {req1_valid, req0_valid};

    // Nothing is accepted while full or during a flush cycle; valids may stay high.
    assign can_accept = !full_reg && !flush;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid_vec),
        .advance (accept_any),
        .grant   (grant_vec)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi]  = can_accept && grant_vec[gi];
            assign accept_vec[gi] = ready_vec[gi] && valid_vec[gi];
            assign err_next[gi]   = accept_vec[gi] && is_zero_div(req_arr[gi]);
        end
    endgenerate

    assign accept_any = |accept_vec;
    assign sel_req    = accept_vec[1] ? req_arr[1] : req_arr[0];
    assign load_next  = accept_any && !is_zero_div(sel_req);

    // Count saturates at DEPTH; the wrap of the pointer is natural at 2**ADDR_W.
    assign count_next = (count_reg == DEPTH_C) ? count_reg : count_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_en_reg   <= 1'b0;
            err_reg       <= 2'b00;
            opcode_reg    <= ZERO;
            operand_a_reg <= '0;
            operand_b_reg <= '0;
            grant_id_reg  <= 1'b0;
        end else begin
            load_en_reg <= load_next;
            err_reg     <= err_next;
            if (load_next) begin
                opcode_reg    <= sel_req.opc;
                operand_a_reg <= sel_req.op_a;
                operand_b_reg <= sel_req.op_b;
                grant_id_reg  <= accept_vec[1];
            end
        end
    end

    // The pointer presented with a beat is the pre-increment value; it moves
    // at the end of that beat. A flush wins over the in-flight beat's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_reg    <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else if (flush) begin
            wp_reg    <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else if (load_en_reg) begin
            wp_reg    <= wp_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
        end
    end

    assign req0_ready    = ready_vec[0];
    assign req1_ready    = ready_vec[1];
    assign req0_err      = err_reg[0];
    assign req1_err      = err_reg[1];
    assign load_en       = load_en_reg;
    assign opcode        = opcode_reg;
    assign operand_a     = operand_a_reg;
    assign operand_b     = operand_b_reg;
    assign grant_id      = grant_id_reg;
    assign write_pointer = wp_reg;
    assign wr_count      = count_reg;
    assign full          = full_reg;

endmodule

// File: tb/tb_instr_load_arbiter.sv
// Self-checking bench for instr_load_arbiter: directed scenarios with literal
// expectations followed by random traffic, all compared every cycle against a
// transaction-level reference model.
module tb_instr_load_arbiter;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] v     = 2'b00;
    opcode_t    opc [2];
    operand_t   opa [2];
    operand_t   opb [2];
    logic [1:0] rdy;
    logic [1:0] err;
    logic       load_en;
    opcode_t    opcode;
    operand_t   operand_a;
    operand_t   operand_b;
    logic [4:0] write_pointer;
    logic [5:0] wr_count;
    logic       full;
    logic       grant_id;

    int n_total = 0;
    int n_pass  = 0;

    instr_load_arbiter #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .req0_valid     (v[0]),
        .req0_ready     (rdy[0]),
        .req0_opcode    (opc[0]),
        .req0_operand_a (opa[0]),
        .req0_operand_b (opb[0]),
        .req0_err       (err[0]),
        .req1_valid     (v[1]),
        .req1_ready     (rdy[1]),
        .req1_opcode    (opc[1]),
        .req1_operand_a (opa[1]),
        .req1_operand_b (opb[1]),
        .req1_err       (err[1]),
        .load_en        (load_en),
        .opcode         (opcode),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .write_pointer  (write_pointer),
        .wr_count       (wr_count),
        .full           (full),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // State: where the next write goes, how many entries are loaded, who won
    // last, and the beat (or error) that the previous cycle's transfer produces.
    int       m_wp, m_cnt, m_last, m_sel, m_gid;
    bit       m_ld, m_can;
    bit [1:0] m_err;
    bit       m_rdy0, m_rdy1;
    opcode_t  m_opc;
    operand_t m_a, m_b;

    always @(negedge clk) begin
        if (reset) begin
            m_wp = 0; m_cnt = 0; m_last = 1; m_ld = 0; m_err = 2'b00;
            m_opc = ZERO; m_a = 0; m_b = 0; m_gid = 0;
            chk("rst_load_en", load_en, 0);
            chk("rst_err", err, 0);
            chk("rst_wp", write_pointer, 0);
            chk("rst_count", wr_count, 0);
            chk("rst_full", full, 0);
            chk("rst_grant", grant_id, 0);
            chk("rst_opcode", opcode, ZERO);
            chk("rst_opa", operand_a, 0);
            chk("rst_opb", operand_b, 0);
        end else begin
            if (v == 2'b11)      m_sel = 1 - m_last;
            else if (v[0])       m_sel = 0;
            else if (v[1])       m_sel = 1;
            else                 m_sel = -1;
            m_can  = (m_cnt != DEPTH) && !flush;
            m_rdy0 = m_can && (m_sel == 0);
            m_rdy1 = m_can && (m_sel == 1);

            chk("ready0", rdy[0], m_rdy0);
            chk("ready1", rdy[1], m_rdy1);
            chk("load_en", load_en, m_ld);
            chk("err", err, m_err);
            chk("write_pointer", write_pointer, m_wp);
            chk("wr_count", wr_count, m_cnt);
            chk("full", full, m_cnt == DEPTH);
            if (m_ld) begin
                chk("opcode", opcode, m_opc);
                chk("operand_a", operand_a, m_a);
                chk("operand_b", operand_b, m_b);
                chk("grant_id", grant_id, m_gid);
            end

            // advance to next cycle
            if (m_ld) begin
                m_wp = (m_wp + 1) % DEPTH;
                if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
            end
            if (flush) begin
                m_wp = 0; m_cnt = 0;
            end
            m_ld = 0; m_err = 2'b00;
            if (m_can && m_sel >= 0) begin
                m_last = m_sel;
                if ((opc[m_sel] == DIV || opc[m_sel] == MOD) && opb[m_sel] == 0) begin
                    m_err[m_sel] = 1'b1;
                end else begin
                    m_ld = 1; m_opc = opc[m_sel]; m_a = opa[m_sel]; m_b = opb[m_sel];
                    m_gid = m_sel;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer one instruction and hold it until accepted; returns at the start
    // of the cycle after the accept (the beat / error cycle).
    task automatic send(input int n, input opcode_t o, input int av, input int bv);
        bit done = 0;
        opc[n] = o; opa[n] = av; opb[n] = bv; v[n] = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (rdy[n]) done = 1;
            tick();
        end
        v[n] = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    int gq[$], aq[$], wq[$];
    int i0, i1, k, last_wp;
    bit acc0, acc1, seen_full;

    initial begin
        for (int n = 0; n < 2; n++) begin
            opc[n] = ZERO; opa[n] = 0; opb[n] = 0;
        end
        tick(); tick(); tick();
        reset = 1'b0;

        // 1: single ADD from requester 0
        send(0, ADD, 5, 3);
        @(negedge clk);
        chk("t1_load_en", load_en, 1);
        chk("t1_wp", write_pointer, 0);
        chk("t1_opcode", opcode, ADD);
        chk("t1_opa", operand_a, 5);
        chk("t1_opb", operand_b, 3);
        chk("t1_grant", grant_id, 0);
        tick();
        @(negedge clk);
        chk("t1_count", wr_count, 1);
        chk("t1_wp_after", write_pointer, 1);

        // 2: contention after a fresh reset
        tick(); reset = 1'b1; tick(); reset = 1'b0;
        i0 = 0; i1 = 0;
        opc[0] = ADD; opc[1] = ADD; opb[0] = 1; opb[1] = 1;
        opa[0] = 1; opa[1] = 11; v = 2'b11;
        for (int c = 0; c < 40 && (i0 < 4 || i1 < 4 || c < 12); c++) begin
            @(negedge clk);
            if (load_en) begin
                gq.push_back(grant_id); aq.push_back(operand_a); wq.push_back(write_pointer);
            end
            acc0 = v[0] && rdy[0];
            acc1 = v[1] && rdy[1];
            tick();
            if (acc0) begin i0++; if (i0 < 4) opa[0] = 1 + i0; else v[0] = 1'b0; end
            if (acc1) begin i1++; if (i1 < 4) opa[1] = 11 + i1; else v[1] = 1'b0; end
        end
        v = 2'b00;
        chk("t2_beats", gq.size(), 8);
        if (gq.size() >= 4) begin
            chk("t2_grant0", gq[0], 0); chk("t2_grant1", gq[1], 1);
            chk("t2_grant2", gq[2], 0); chk("t2_grant3", gq[3], 1);
            chk("t2_opa0", aq[0], 1);   chk("t2_opa1", aq[1], 11);
            chk("t2_opa2", aq[2], 2);   chk("t2_opa3", aq[3], 12);
            chk("t2_wp0", wq[0], 0);    chk("t2_wp3", wq[3], 3);
        end

        // 3: DIV by zero rejected, then a good DIV
        send(1, DIV, 10, 0);
        @(negedge clk);
        chk("t3_err1", err[1], 1);
        chk("t3_load_en", load_en, 0);
        chk("t3_count", wr_count, 8);
        chk("t3_wp", write_pointer, 8);
        tick();
        @(negedge clk);
        chk("t3_err1_pulse", err[1], 0);
        chk("t3_count_hold", wr_count, 8);
        tick();
        send(1, DIV, 10, 2);
        @(negedge clk);
        chk("t3_div_load", load_en, 1);
        chk("t3_div_wp", write_pointer, 8);
        chk("t3_div_opb", operand_b, 2);

        // 4: fill all 32 entries
        tick(); flush = 1'b1; tick(); flush = 1'b0;
        k = 0; last_wp = -1; opc[0] = SUB; opb[0] = 7; opa[0] = 100; v[0] = 1'b1;
        for (int c = 0; c < 200 && (k < 32 || c < 40); c++) begin
            @(negedge clk);
            if (load_en) last_wp = write_pointer;
            acc0 = v[0] && rdy[0];
            tick();
            if (acc0) begin k++; opa[0] = 100 + k; if (k == 32) v[0] = 1'b0; end
        end
        chk("t4_loads", k, 32);
        chk("t4_last_wp", last_wp, 31);
        seen_full = 0;
        for (int c = 0; c < 10 && !seen_full; c++) begin
            @(negedge clk);
            seen_full = full;
            if (!seen_full) tick();
        end
        chk("t4_full", full, 1);
        chk("t4_count", wr_count, 32);
        chk("t4_wp_wrap", write_pointer, 0);
        tick();
        opa[0] = 999; opb[0] = 9; opc[0] = MULT; v[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_blocked_ready", rdy[0], 0);
            chk("t4_blocked_load", load_en, 0);
            tick();
        end

        // 5: flush releases the held request into entry 0
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_ready", rdy[0], 0);
        tick(); flush = 1'b0;
        @(negedge clk);
        chk("t5_count", wr_count, 0);
        chk("t5_wp", write_pointer, 0);
        chk("t5_full", full, 0);
        chk("t5_ready", rdy[0], 1);
        tick(); v[0] = 1'b0;
        @(negedge clk);
        chk("t5_load", load_en, 1);
        chk("t5_load_wp", write_pointer, 0);
        chk("t5_load_opa", operand_a, 999);
        tick();

        // 6: reset during the beat cycle discards the beat
        send(0, SUB, 7, 4);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_load_en", load_en, 0);
        chk("t6_count", wr_count, 0);
        tick(); reset = 1'b0;
        send(0, ADD, 1, 1);
        @(negedge clk);
        chk("t6_next_load", load_en, 1);
        chk("t6_next_wp", write_pointer, 0);
        tick();

        // random traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc0 = v[0] && rdy[0] && !reset;
            acc1 = v[1] && rdy[1] && !reset;
            tick();
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int n = 0; n < 2; n++) begin
                if (!v[n] || (n == 0 ? acc0 : acc1)) begin
                    v[n]   = ($urandom_range(0, 3) != 0);
                    opc[n] = opcode_t'($urandom_range(0, 7));
                    opa[n] = $urandom;
                    opb[n] = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
                end
            end
        end
        reset = 1'b0; flush = 1'b0; v = 2'b00;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
